// File: rtl/dmx_pkg.sv
// Shared types and constants for the FPGA-side SPI link.
// Word layout is {param[7:0], value[7:0]}, sent MSB-first.
package dmx_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } tx_state_t;

  localparam int SPI_WORD_W = 16;
  localparam int PARAM_MSB  = 15;
  localparam int VALUE_MSB  = 7;

  function automatic logic [SPI_WORD_W-1:0] pack_word(input logic [7:0] param,
                                                      input logic [7:0] value);
    logic [SPI_WORD_W-1:0] w;
    w = '0;
    w[PARAM_MSB -: 8] = param;
    w[VALUE_MSB -: 8] = value;
    return w;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer with registered rise/fall detect.
// A pin edge shows up on rise/fall STAGES+1 clocks later.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic int_osc,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  assign level = sync_q[STAGES-1];

  // RST_VAL lets a line that is already high at reset release look steady,
  // so no spurious edge is reported.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= level;
      rise   <= level & ~prev_q;
      fall   <= ~level & prev_q;
    end
  end

endmodule

// File: rtl/spi_tx_fsm.sv
// SPI slave transmitter: holds one status word and shifts it out MSB-first
// on sdo during the next SPILoad-framed transfer; runs entirely on int_osc.
//
// state     | meaning
// WAIT_IDLE | after reset; wait for SPILoad low before honouring a frame
// IDLE      | between frames; load_rise starts a frame
// SHIFT     | in a frame; count sclk rises, shift on sclk falls
module spi_tx_fsm
  import dmx_pkg::*;
#(
  parameter int WIDTH       = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             int_osc,
  input  logic             reset,
  input  logic             sclk,
  input  logic             SPILoad,
  input  logic [WIDTH-1:0] tx_word,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sdo,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             underrun
);

  localparam int              CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_SAT   = CW'(WIDTH + 1);

  tx_state_t         state;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  hold_q;
  logic              hold_valid;
  logic [CW-1:0]     bit_cnt;
  logic              accept;

  logic unused_sclk_level;
  logic sclk_rise, sclk_fall;
  logic load_level, load_rise, load_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .int_osc (int_osc),
    .reset   (reset),
    .din     (sclk),
    .level   (unused_sclk_level),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // Reset high so a frame already in progress at reset release is not
  // mistaken for a new one.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
    .int_osc (int_osc),
    .reset   (reset),
    .din     (SPILoad),
    .level   (load_level),
    .rise    (load_rise),
    .fall    (load_fall)
  );

  assign tx_ready = ~hold_valid;
  assign accept   = tx_valid & tx_ready;
  assign sdo      = shift_q[WIDTH-1];

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_valid  <= 1'b0;
      bit_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;

      if (accept) begin
        hold_q     <= tx_word;
        hold_valid <= 1'b1;
        underrun   <= 1'b0;
      end

      case (state)
        WAIT_IDLE: begin
          if (!load_level) state <= IDLE;
        end

        IDLE: begin
          if (load_rise) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            if (accept) begin
              shift_q    <= tx_word;
              hold_valid <= 1'b0;
            end else if (hold_valid) begin
              shift_q    <= hold_q;
              hold_valid <= 1'b0;
            end else begin
              shift_q  <= '0;
              underrun <= 1'b1;
            end
          end
        end

        SHIFT: begin
          // Frame end wins over a coincident sclk edge.
          if (load_fall) begin
            state   <= IDLE;
            shift_q <= '0;
            if (bit_cnt == CNT_FULL) frame_done  <= 1'b1;
            else                     frame_abort <= 1'b1;
          end else begin
            if (sclk_rise && bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
            if (sclk_fall) shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_fsm.sv
// Directed + randomized bench for spi_tx_fsm with an MCU-side frame model.
module tb_spi_tx_fsm;
  import dmx_pkg::*;

  logic        int_osc = 1'b0;
  logic        reset   = 1'b0;
  logic        sclk    = 1'b0;
  logic        SPILoad = 1'b0;
  logic [15:0] tx_word = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, sdo, frame_done, frame_abort, underrun;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic sdo_or = 1'b0;

  // reference model of the word-holding side
  logic        m_hold_valid = 1'b0;
  logic [15:0] m_hold = '0;
  logic        m_underrun = 1'b0;

  spi_tx_fsm #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .int_osc     (int_osc),
    .reset       (reset),
    .sclk        (sclk),
    .SPILoad     (SPILoad),
    .tx_word     (tx_word),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .sdo         (sdo),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .underrun    (underrun)
  );

  always #5 int_osc = ~int_osc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge int_osc);
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
    sdo_or = sdo_or | sdo;
  endtask

  task automatic do_accept(input logic [15:0] w);
    check("ready_before_accept", 32'(tx_ready), 32'(!m_hold_valid));
    tx_word  = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    m_hold       = w;
    m_hold_valid = 1'b1;
    m_underrun   = 1'b0;
    check("ready_after_accept", 32'(tx_ready), 32'(0));
    check("underrun_after_accept", 32'(underrun), 32'(0));
  endtask

  // One MCU frame of n sclk periods at int_osc/16; optional same-cycle
  // bypass accept and mid-frame accept.
  task automatic run_frame(input int n, input bit bypass, input logic [15:0] bword,
                           input bit mid, input logic [15:0] mword);
    logic [15:0] sent;
    logic [31:0] cap, exp;
    int d0, a0, setup;
    d0 = done_cnt;
    a0 = abort_cnt;
    cap = '0;
    exp = '0;
    setup = 10;
    SPILoad = 1'b1;
    if (bypass) begin
      repeat (3) tick();
      tx_word  = bword;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("bypass_ready", 32'(tx_ready), 32'(1));
      setup = 6;
      sent = bword;
      m_underrun = 1'b0;
    end else if (m_hold_valid) begin
      sent = m_hold;
      m_hold_valid = 1'b0;
    end else begin
      sent = '0;
      m_underrun = 1'b1;
    end
    repeat (setup) tick();
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      cap = {cap[30:0], sdo};
      repeat (8) tick();
      sclk = 1'b0;
      if (mid && i == n / 2) do_accept(mword);
      repeat (8) tick();
    end
    repeat (8) tick();
    SPILoad = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < n; i++)
      exp = {exp[30:0], (i < 16) ? sent[15 - i] : 1'b0};
    check("captured", cap, exp);
    check("done_pulses", 32'(done_cnt - d0), 32'(n == 16));
    check("abort_pulses", 32'(abort_cnt - a0), 32'(n != 16));
    check("underrun", 32'(underrun), 32'(m_underrun));
    check("tx_ready", 32'(tx_ready), 32'(!m_hold_valid));
  endtask

  initial begin
    logic [15:0] rw, rw2;
    int d0, a0, n, mode;
    bit bp, mid;

    repeat (3) tick();
    check("rst_sdo", 32'(sdo), 32'(0));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_frame_abort", 32'(frame_abort), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    reset = 1'b1;
    repeat (8) tick();

    do_accept(pack_word(8'hA5, 8'h5A));
    run_frame(16, 1'b0, '0, 1'b0, '0);

    run_frame(16, 1'b0, '0, 1'b0, '0);
    do_accept(16'h1234);
    run_frame(16, 1'b0, '0, 1'b0, '0);

    run_frame(16, 1'b1, 16'h00FF, 1'b0, '0);

    do_accept(16'hC3E1);
    run_frame(9, 1'b0, '0, 1'b0, '0);
    do_accept(16'hB00D);
    run_frame(18, 1'b0, '0, 1'b0, '0);

    do_accept(16'h8001);
    run_frame(16, 1'b0, '0, 1'b1, 16'h7FFE);
    run_frame(16, 1'b0, '0, 1'b0, '0);

    // reset after 5 sclk edges with SPILoad still high
    do_accept(16'h5AA5);
    SPILoad = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      repeat (8) tick();
      if (i < 2) begin
        sclk = 1'b0;
        repeat (8) tick();
      end
    end
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    m_hold_valid = 1'b0;
    m_underrun   = 1'b0;
    d0 = done_cnt;
    a0 = abort_cnt;
    sdo_or = 1'b0;
    sclk = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 13; i++) begin
      sclk = 1'b1;
      repeat (8) tick();
      sclk = 1'b0;
      repeat (8) tick();
    end
    repeat (8) tick();
    SPILoad = 1'b0;
    repeat (12) tick();
    check("post_rst_sdo_quiet", 32'(sdo_or), 32'(0));
    check("post_rst_done", 32'(done_cnt - d0), 32'(0));
    check("post_rst_abort", 32'(abort_cnt - a0), 32'(0));
    check("post_rst_ready", 32'(tx_ready), 32'(1));
    do_accept(16'h3C96);
    run_frame(16, 1'b0, '0, 1'b0, '0);

    for (int k = 0; k < 10; k++) begin
      rw   = 16'($urandom);
      rw2  = 16'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 1 && !m_hold_valid) do_accept(rw);
      bp  = (mode == 2) && !m_hold_valid;
      mid = ($urandom_range(0, 3) == 0);
      n   = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(1, 20));
      run_frame(n, bp, rw, mid, rw2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
